// File: rtl/sig_freq_meter.sv
// rtl/sig_freq_meter.sv - rising-edge frequency/period meter for a square wave, in clk_in cycles
module sig_freq_meter #(
   parameter int GATE_CYCLES = 30000,
   parameter int CNT_W       = 16,
   parameter int PER_W       = 24
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             enable,
   input  logic             sig_in,
   output logic [CNT_W-1:0] edge_count,
   output logic             count_valid,
   output logic [PER_W-1:0] period,
   output logic             period_valid,
   output logic             stalled
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ARM  = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;

   localparam int              GW        = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [PER_W-1:0] PER_MAX  = '1;

   logic             s1, s2, s3;
   logic             rise;
   logic [1:0]       state;
   logic [GW-1:0]    gate_cnt;
   logic [CNT_W-1:0] edge_acc;
   logic [CNT_W-1:0] acc_next;
   logic [PER_W-1:0] per_cnt;

   assign rise     = s2 & ~s3;
   assign acc_next = (rise && edge_acc != CNT_MAX) ? edge_acc + 1'b1 : edge_acc;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         s1           <= 1'b0;
         s2           <= 1'b0;
         s3           <= 1'b0;
         state        <= IDLE;
         gate_cnt     <= '0;
         edge_acc     <= '0;
         per_cnt      <= '0;
         edge_count   <= '0;
         period       <= '0;
         count_valid  <= 1'b0;
         period_valid <= 1'b0;
         stalled      <= 1'b0;
      end else begin
         s1           <= sig_in;
         s2           <= s1;
         s3           <= s2;
         count_valid  <= 1'b0;
         period_valid <= 1'b0;
         if (state == IDLE) begin
            gate_cnt <= '0;
            edge_acc <= '0;
            per_cnt  <= '0;
            if (enable)
               state <= ARM;
         end else if (!enable) begin
            // partial window and period are simply abandoned; results hold
            state   <= IDLE;
            stalled <= 1'b0;
         end else begin
            // gate windows run back to back, independent of the period path
            if (gate_cnt == GATE_LAST) begin
               edge_count  <= acc_next;
               count_valid <= 1'b1;
               gate_cnt    <= '0;
               edge_acc    <= '0;
            end else begin
               gate_cnt <= gate_cnt + 1'b1;
               edge_acc <= acc_next;
            end
            if (state == ARM) begin
               if (rise) begin
                  state   <= RUN;
                  per_cnt <= PER_W'(1);
                  stalled <= 1'b0;
               end
            end else if (per_cnt == PER_MAX) begin
               stalled <= 1'b1;
               state   <= ARM;
            end else if (rise) begin
               period       <= per_cnt;
               period_valid <= 1'b1;
               per_cnt      <= PER_W'(1);
            end else begin
               per_cnt <= per_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sig_freq_meter.sv
// tb/tb_sig_freq_meter.sv - randomized bench for sig_freq_meter against a timestamp-based model
module tb_sig_freq_meter;

   localparam int G  = 40;
   localparam int CW = 4;
   localparam int PW = 7;
   localparam int SAT  = (1 << CW) - 1;
   localparam int PMAX = (1 << PW) - 1;

   logic          clk_in = 1'b0;
   logic          rst;
   logic          enable;
   logic          sig_in;
   logic [CW-1:0] edge_count;
   logic          count_valid;
   logic [PW-1:0] period;
   logic          period_valid;
   logic          stalled;

   int total = 0;
   int bad   = 0;

   // model: edges are timestamped, windows are located relative to the arming edge
   longint cyc = 0;
   longint arm_at, last_rise;
   int     m_mode = 0;  // 0 off, 1 waiting for first edge, 2 measuring
   int     cnt = 0;
   bit     h1 = 0, h2 = 0, h3 = 0;
   int     e_ec = 0, e_per = 0, e_cv = 0, e_pv = 0, e_st = 0;

   always #5 clk_in = ~clk_in;

   sig_freq_meter #(.GATE_CYCLES(G), .CNT_W(CW), .PER_W(PW)) dut (
      .clk_in       (clk_in),
      .rst          (rst),
      .enable       (enable),
      .sig_in       (sig_in),
      .edge_count   (edge_count),
      .count_valid  (count_valid),
      .period       (period),
      .period_valid (period_valid),
      .stalled      (stalled)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      bit     r;
      longint d;
      @(posedge clk_in);
      cyc++;
      r  = h2 & ~h3;
      h3 = h2;
      h2 = h1;
      h1 = sig_in;
      if (rst) begin
         h1 = 0; h2 = 0; h3 = 0;
         m_mode = 0; cnt = 0;
         e_ec = 0; e_per = 0; e_cv = 0; e_pv = 0; e_st = 0;
      end else begin
         e_cv = 0;
         e_pv = 0;
         if (m_mode == 0) begin
            if (enable) begin
               m_mode = 1;
               arm_at = cyc;
               cnt    = 0;
            end
         end else if (!enable) begin
            m_mode = 0;
            e_st   = 0;
         end else begin
            cnt += int'(r);
            if (((cyc - arm_at - 1) % G) == G - 1) begin
               e_ec = (cnt > SAT) ? SAT : cnt;
               e_cv = 1;
               cnt  = 0;
            end
            if (m_mode == 1) begin
               if (r) begin
                  m_mode    = 2;
                  last_rise = cyc;
                  e_st      = 0;
               end
            end else begin
               d = cyc - last_rise;
               if (d == PMAX) begin
                  e_st   = 1;
                  m_mode = 1;
               end else if (r) begin
                  e_per     = int'(d);
                  e_pv      = 1;
                  last_rise = cyc;
               end
            end
         end
      end
      #1;
      check("count_valid", longint'(count_valid), e_cv);
      check("period_valid", longint'(period_valid), e_pv);
      check("stalled", longint'(stalled), e_st);
      check("edge_count", longint'(edge_count), e_ec);
      check("period", longint'(period), e_per);
   endtask

   // kind: 0 random level, 1 toggle every arg cycles, 2 hold low, 3 one-cycle pulse every arg cycles
   task automatic run(input int n, input int kind, input int arg, input int drop_at, input int rst_at);
      int ph;
      ph = 0;
      for (int i = 0; i < n; i++) begin
         case (kind)
            0: sig_in = 1'($urandom_range(0, 1));
            1: begin
               if (ph == 0) sig_in = ~sig_in;
               ph = (ph + 1) % arg;
            end
            2: sig_in = 1'b0;
            default: begin
               sig_in = (ph == 0);
               ph = (ph + 1) % arg;
            end
         endcase
         enable = !(drop_at >= 0 && i >= drop_at && i < drop_at + 4);
         rst    = (i == rst_at);
         step();
      end
   endtask

   initial begin
      int kind, arg, n, drop, ra;
      rst    = 1'b1;
      enable = 1'b0;
      sig_in = 1'b0;
      step();
      step();
      rst    = 1'b0;
      enable = 1'b1;

      run(300, 1, 2, -1, -1);
      check("period_of_4", longint'(period), 4);
      check("count_of_10", longint'(edge_count), 10);

      run(200, 1, 1, -1, -1);
      check("saturated_count", longint'(edge_count), SAT);
      check("period_of_2", longint'(period), 2);

      run(300, 1, 3, 150, -1);
      run(200, 1, 2, -1, 77);

      run(160, 2, 1, -1, -1);
      check("stalled_after_hold", longint'(stalled), 1);
      run(100, 3, 8, -1, -1);
      check("period_of_8", longint'(period), 8);
      check("stall_cleared", longint'(stalled), 0);

      run(400, 3, PMAX - 1, -1, -1);
      run(400, 3, PMAX, -1, -1);
      run(400, 3, PMAX + 1, -1, -1);
      run(100, 3, G, -1, -1);

      for (int k = 0; k < 16; k++) begin
         kind = int'($urandom_range(0, 3));
         arg  = (kind == 1) ? int'($urandom_range(1, 6)) :
                (kind == 3) ? int'($urandom_range(2, 140)) : 1;
         n    = int'($urandom_range(60, 400));
         drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         ra   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         run(n, kind, arg, drop, ra);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
